// File: rtl/axil_arbiter_2.sv
// Two-master to one-slave AXI4-Lite arbiter with independent read and write grants.
// Build option: define AXIL_ARB_RR_EN for round-robin on contested requests (default: a0 first).
module axil_arbiter_2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // master a0
  input  logic                  a0_awvalid,
  input  logic [ADDR_WIDTH-1:0] a0_awaddr,
  output logic                  a0_awready,
  input  logic                  a0_wvalid,
  input  logic [DATA_WIDTH-1:0] a0_wdata,
  input  logic [STRB_WIDTH-1:0] a0_wstrb,
  output logic                  a0_wready,
  output logic                  a0_bvalid,
  output logic [1:0]            a0_bresp,
  input  logic                  a0_bready,
  input  logic                  a0_arvalid,
  input  logic [ADDR_WIDTH-1:0] a0_araddr,
  output logic                  a0_arready,
  output logic                  a0_rvalid,
  output logic [DATA_WIDTH-1:0] a0_rdata,
  output logic [1:0]            a0_rresp,
  input  logic                  a0_rready,
  // master a1
  input  logic                  a1_awvalid,
  input  logic [ADDR_WIDTH-1:0] a1_awaddr,
  output logic                  a1_awready,
  input  logic                  a1_wvalid,
  input  logic [DATA_WIDTH-1:0] a1_wdata,
  input  logic [STRB_WIDTH-1:0] a1_wstrb,
  output logic                  a1_wready,
  output logic                  a1_bvalid,
  output logic [1:0]            a1_bresp,
  input  logic                  a1_bready,
  input  logic                  a1_arvalid,
  input  logic [ADDR_WIDTH-1:0] a1_araddr,
  output logic                  a1_arready,
  output logic                  a1_rvalid,
  output logic [DATA_WIDTH-1:0] a1_rdata,
  output logic [1:0]            a1_rresp,
  input  logic                  a1_rready,
  // shared slave port
  output logic                  m_awvalid,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  input  logic                  m_awready,
  output logic                  m_wvalid,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  input  logic [1:0]            m_bresp,
  output logic                  m_bready,
  output logic                  m_arvalid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  m_rready
);

  typedef enum logic [1:0] {WIdle, WAddr, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_e w_state_q, w_state_d;
  logic     wgnt_q, wgnt_d;
  logic     aw_done_q, aw_done_d;
  logic     w_done_q, w_done_d;
  logic     w_win;
  logic     w_addr_act, w_resp_act;
  logic     g_awvalid, g_wvalid, g_bready;
  logic     aw_rdy, w_rdy, b_vld;

`ifdef AXIL_ARB_RR_EN
  logic wlast_q, wlast_d;
`endif

  always_comb begin
    if (a0_awvalid && a1_awvalid) begin
`ifdef AXIL_ARB_RR_EN
      w_win = ~wlast_q;
`else
      w_win = 1'b0;
`endif
    end else begin
      w_win = a1_awvalid;
    end
  end

  // Outputs are gated by aresetn so nothing is offered while reset is held.
  assign w_addr_act = aresetn && (w_state_q == WAddr);
  assign w_resp_act = aresetn && (w_state_q == WResp);

  assign g_awvalid = wgnt_q ? a1_awvalid : a0_awvalid;
  assign g_wvalid  = wgnt_q ? a1_wvalid  : a0_wvalid;
  assign g_bready  = wgnt_q ? a1_bready  : a0_bready;

  assign m_awaddr = wgnt_q ? a1_awaddr : a0_awaddr;
  assign m_wdata  = wgnt_q ? a1_wdata  : a0_wdata;
  assign m_wstrb  = wgnt_q ? a1_wstrb  : a0_wstrb;
  assign a0_bresp = m_bresp;
  assign a1_bresp = m_bresp;

  always_comb begin
    m_awvalid  = w_addr_act & g_awvalid & ~aw_done_q;
    m_wvalid   = w_addr_act & g_wvalid & ~w_done_q;
    m_bready   = w_resp_act & g_bready;
    aw_rdy     = w_addr_act & m_awready & ~aw_done_q;
    w_rdy      = w_addr_act & m_wready & ~w_done_q;
    b_vld      = w_resp_act & m_bvalid;
    a0_awready = aw_rdy & ~wgnt_q;
    a1_awready = aw_rdy & wgnt_q;
    a0_wready  = w_rdy & ~wgnt_q;
    a1_wready  = w_rdy & wgnt_q;
    a0_bvalid  = b_vld & ~wgnt_q;
    a1_bvalid  = b_vld & wgnt_q;
  end

  always_comb begin
    w_state_d = w_state_q;
    wgnt_d    = wgnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef AXIL_ARB_RR_EN
    wlast_d   = wlast_q;
`endif
    unique case (w_state_q)
      WIdle: begin
        if (a0_awvalid || a1_awvalid) begin
          wgnt_d    = w_win;
          w_state_d = WAddr;
        end
      end
      WAddr: begin
        aw_done_d = aw_done_q | (m_awvalid & m_awready);
        w_done_d  = w_done_q | (m_wvalid & m_wready);
        if (aw_done_d && w_done_d) begin
          w_state_d = WResp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WResp: begin
        if (m_bvalid && m_bready) begin
`ifdef AXIL_ARB_RR_EN
          wlast_d = wgnt_q;
`endif
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q <= WIdle;
      wgnt_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wgnt_q    <= wgnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef AXIL_ARB_RR_EN
  // Reset to a1 as "last" so a0 wins the first contested round.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wlast_q <= 1'b1;
    end else begin
      wlast_q <= wlast_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_e r_state_q, r_state_d;
  logic     rgnt_q, rgnt_d;
  logic     r_win;
  logic     r_addr_act, r_data_act;
  logic     g_arvalid, g_rready;
  logic     ar_rdy, r_vld;

`ifdef AXIL_ARB_RR_EN
  logic rlast_q, rlast_d;
`endif

  always_comb begin
    if (a0_arvalid && a1_arvalid) begin
`ifdef AXIL_ARB_RR_EN
      r_win = ~rlast_q;
`else
      r_win = 1'b0;
`endif
    end else begin
      r_win = a1_arvalid;
    end
  end

  assign r_addr_act = aresetn && (r_state_q == RAddr);
  assign r_data_act = aresetn && (r_state_q == RData);

  assign g_arvalid = rgnt_q ? a1_arvalid : a0_arvalid;
  assign g_rready  = rgnt_q ? a1_rready  : a0_rready;

  assign m_araddr = rgnt_q ? a1_araddr : a0_araddr;
  assign a0_rdata = m_rdata;
  assign a1_rdata = m_rdata;
  assign a0_rresp = m_rresp;
  assign a1_rresp = m_rresp;

  always_comb begin
    m_arvalid  = r_addr_act & g_arvalid;
    m_rready   = r_data_act & g_rready;
    ar_rdy     = r_addr_act & m_arready;
    r_vld      = r_data_act & m_rvalid;
    a0_arready = ar_rdy & ~rgnt_q;
    a1_arready = ar_rdy & rgnt_q;
    a0_rvalid  = r_vld & ~rgnt_q;
    a1_rvalid  = r_vld & rgnt_q;
  end

  always_comb begin
    r_state_d = r_state_q;
    rgnt_d    = rgnt_q;
`ifdef AXIL_ARB_RR_EN
    rlast_d   = rlast_q;
`endif
    unique case (r_state_q)
      RIdle: begin
        if (a0_arvalid || a1_arvalid) begin
          rgnt_d    = r_win;
          r_state_d = RAddr;
        end
      end
      RAddr: begin
        if (m_arvalid && m_arready) begin
          r_state_d = RData;
        end
      end
      RData: begin
        if (m_rvalid && m_rready) begin
`ifdef AXIL_ARB_RR_EN
          rlast_d = rgnt_q;
`endif
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state_q <= RIdle;
      rgnt_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rgnt_q    <= rgnt_d;
    end
  end

`ifdef AXIL_ARB_RR_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rlast_q <= 1'b1;
    end else begin
      rlast_q <= rlast_d;
    end
  end
`endif

endmodule

// File: tb/tb_axil_arbiter_2.sv
// Self-checking bench for axil_arbiter_2: bus-functional masters/slave plus a scoreboard.
// Expected grant order follows AXIL_ARB_RR_EN the same way as the design build.
module tb_axil_arbiter_2;

  logic aclk, aresetn;
  logic a0_awvalid, a0_awready, a0_wvalid, a0_wready, a0_bvalid, a0_bready;
  logic a0_arvalid, a0_arready, a0_rvalid, a0_rready;
  logic a1_awvalid, a1_awready, a1_wvalid, a1_wready, a1_bvalid, a1_bready;
  logic a1_arvalid, a1_arready, a1_rvalid, a1_rready;
  logic [31:0] a0_awaddr, a0_wdata, a0_araddr, a0_rdata;
  logic [31:0] a1_awaddr, a1_wdata, a1_araddr, a1_rdata;
  logic [3:0]  a0_wstrb, a1_wstrb, m_wstrb;
  logic [1:0]  a0_bresp, a0_rresp, a1_bresp, a1_rresp, m_bresp, m_rresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;

  logic [4:0]  a0_vr, a1_vr, m_vr;
  logic [14:0] all_vr;
  assign a0_vr  = {a0_awready, a0_wready, a0_bvalid, a0_arready, a0_rvalid};
  assign a1_vr  = {a1_awready, a1_wready, a1_bvalid, a1_arready, a1_rvalid};
  assign m_vr   = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
  assign all_vr = {a0_vr, a1_vr, m_vr};

  axil_arbiter_2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .a0_awvalid(a0_awvalid), .a0_awaddr(a0_awaddr), .a0_awready(a0_awready),
    .a0_wvalid(a0_wvalid), .a0_wdata(a0_wdata), .a0_wstrb(a0_wstrb), .a0_wready(a0_wready),
    .a0_bvalid(a0_bvalid), .a0_bresp(a0_bresp), .a0_bready(a0_bready),
    .a0_arvalid(a0_arvalid), .a0_araddr(a0_araddr), .a0_arready(a0_arready),
    .a0_rvalid(a0_rvalid), .a0_rdata(a0_rdata), .a0_rresp(a0_rresp), .a0_rready(a0_rready),
    .a1_awvalid(a1_awvalid), .a1_awaddr(a1_awaddr), .a1_awready(a1_awready),
    .a1_wvalid(a1_wvalid), .a1_wdata(a1_wdata), .a1_wstrb(a1_wstrb), .a1_wready(a1_wready),
    .a1_bvalid(a1_bvalid), .a1_bresp(a1_bresp), .a1_bready(a1_bready),
    .a1_arvalid(a1_arvalid), .a1_araddr(a1_araddr), .a1_arready(a1_arready),
    .a1_rvalid(a1_rvalid), .a1_rdata(a1_rdata), .a1_rresp(a1_rresp), .a1_rready(a1_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        who;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rec_t;

  rec_t exp_w[$], got_w[$], exp_r[$], got_r[$];
  int errors = 0;
  int checks = 0;
  int excl_viol = 0;
  int w_hs_cnt = 0;
  logic sl_aw, sl_w;
  logic [1:0]  sl_bresp;
  logic [31:0] sl_rdata, cap_awaddr, cap_wdata, cap_araddr;

  // One clock of master and slave bus-functional behaviour; records completed responses.
  task automatic mstep();
    logic h_aw0, h_aw1, h_w0, h_w1, h_ar0, h_ar1, h_maw, h_mw, h_mb, h_mar, h_mr;
    rec_t r;
    #1;
    h_aw0 = a0_awvalid & a0_awready;
    h_aw1 = a1_awvalid & a1_awready;
    h_w0  = a0_wvalid & a0_wready;
    h_w1  = a1_wvalid & a1_wready;
    h_ar0 = a0_arvalid & a0_arready;
    h_ar1 = a1_arvalid & a1_arready;
    h_maw = m_awvalid & m_awready;
    h_mw  = m_wvalid & m_wready;
    h_mb  = m_bvalid & m_bready;
    h_mar = m_arvalid & m_arready;
    h_mr  = m_rvalid & m_rready;
    if ((a0_awready | a0_wready | a0_bvalid) & (a1_awready | a1_wready | a1_bvalid)) excl_viol++;
    if ((a0_arready | a0_rvalid) & (a1_arready | a1_rvalid)) excl_viol++;
    if (a0_bvalid & a0_bready) begin
      r = {1'b0, cap_awaddr, cap_wdata, a0_bresp}; got_w.push_back(r);
    end
    if (a1_bvalid & a1_bready) begin
      r = {1'b1, cap_awaddr, cap_wdata, a1_bresp}; got_w.push_back(r);
    end
    if (a0_rvalid & a0_rready) begin
      r = {1'b0, cap_araddr, a0_rdata, a0_rresp}; got_r.push_back(r);
    end
    if (a1_rvalid & a1_rready) begin
      r = {1'b1, cap_araddr, a1_rdata, a1_rresp}; got_r.push_back(r);
    end
    if (h_maw) begin cap_awaddr = m_awaddr; sl_aw = 1'b1; end
    if (h_mw) begin cap_wdata = m_wdata; sl_w = 1'b1; w_hs_cnt++; end
    if (h_mar) cap_araddr = m_araddr;
    @(posedge aclk);
    #1;
    if (h_aw0) a0_awvalid = 1'b0;
    if (h_aw1) a1_awvalid = 1'b0;
    if (h_w0) a0_wvalid = 1'b0;
    if (h_w1) a1_wvalid = 1'b0;
    if (h_ar0) a0_arvalid = 1'b0;
    if (h_ar1) a1_arvalid = 1'b0;
    if (!aresetn) begin
      sl_aw = 1'b0; sl_w = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
    end else begin
      if (h_mb) m_bvalid = 1'b0;
      if (h_mr) m_rvalid = 1'b0;
      if (sl_aw && sl_w) begin
        m_bvalid = 1'b1; m_bresp = sl_bresp; sl_aw = 1'b0; sl_w = 1'b0;
      end
      if (h_mar) begin m_rvalid = 1'b1; m_rdata = sl_rdata; m_rresp = 2'b00; end
    end
    #1;
  endtask

  task automatic issue_write(input logic who, input logic [31:0] addr, input logic [31:0] data);
    if (who) begin
      a1_awvalid = 1'b1; a1_awaddr = addr; a1_wvalid = 1'b1; a1_wdata = data; a1_wstrb = 4'hF;
    end else begin
      a0_awvalid = 1'b1; a0_awaddr = addr; a0_wvalid = 1'b1; a0_wdata = data; a0_wstrb = 4'hF;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    a0_awvalid = 1'b1; a0_wvalid = 1'b1; a1_arvalid = 1'b1;
    repeat (3) mstep();
    checks++;
    if (all_vr !== 15'h0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0000", all_vr);
    end
    a0_awvalid = 1'b0; a0_wvalid = 1'b0; a1_arvalid = 1'b0;
    aresetn = 1'b1;
    repeat (2) mstep();
    checks++;
    if (all_vr !== 15'h0) begin
      errors++; $display("FAIL reset_idle: got %h expected 0000", all_vr);
    end
  endtask

  task automatic test_single_write();
    rec_t e, g;
    int n;
    sl_bresp = 2'b00;
    e = {1'b1, 32'h10, 32'hDEADBEEF, 2'b00}; exp_w.push_back(e);
    issue_write(1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, a1_awready} !== 3'b000) begin
      errors++; $display("FAIL single_arb_cycle: got %b expected 000", {m_awvalid, m_wvalid, a1_awready});
    end
    mstep();
    checks++;
    if ({m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb} !== {2'b11, 32'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL single_fwd: got v=%b addr=%h data=%h strb=%h expected v=11 addr=10 data=deadbeef strb=f",
                         {m_awvalid, m_wvalid}, m_awaddr, m_wdata, m_wstrb);
    end
    checks++;
    if (a0_vr !== 5'b0) begin
      errors++; $display("FAIL single_a0_quiet: got %b expected 00000", a0_vr);
    end
    n = 0;
    while (got_w.size() == 0 && n < 10) begin mstep(); n++; end
    checks++;
    if (got_w.size() == 0) begin
      errors++; $display("FAIL single_timeout: got no response expected one");
    end else begin
      g = got_w.pop_front(); e = exp_w.pop_front();
      if (g !== e || n != 2) begin
        errors++; $display("FAIL single_resp: got %h after %0d expected %h after 2", g, n, e);
      end
    end
  endtask

  task automatic test_contested_writes();
    rec_t e, g;
    int i0, i1, n, who, idx;
    logic busy0, busy1;
    for (int k = 0; k < 8; k++) begin
`ifdef AXIL_ARB_RR_EN
      who = k % 2; idx = k / 2;
`else
      who = (k >= 4) ? 1 : 0; idx = k % 4;
`endif
      e.who  = (who == 1);
      e.addr = (who == 1) ? 32'h200 + 32'(idx * 4) : 32'h100 + 32'(idx * 4);
      e.data = (who == 1) ? 32'hB100_0000 + 32'(idx) : 32'hA000_0000 + 32'(idx);
      e.resp = 2'b00;
      exp_w.push_back(e);
    end
    i0 = 0; i1 = 0; busy0 = 1'b0; busy1 = 1'b0; n = 0;
    while ((i0 < 4 || i1 < 4 || busy0 || busy1) && n < 200) begin
      if (!busy0 && i0 < 4) begin
        issue_write(1'b0, 32'h100 + 32'(i0 * 4), 32'hA000_0000 + 32'(i0)); busy0 = 1'b1; i0++;
      end
      if (!busy1 && i1 < 4) begin
        issue_write(1'b1, 32'h200 + 32'(i1 * 4), 32'hB100_0000 + 32'(i1)); busy1 = 1'b1; i1++;
      end
      mstep(); n++;
      while (got_w.size() > 0) begin
        g = got_w.pop_front();
        checks++;
        if (exp_w.size() == 0) begin
          errors++; $display("FAIL contest_extra: got %h expected none", g);
        end else begin
          e = exp_w.pop_front();
          if (g !== e) begin
            errors++; $display("FAIL contest_order: got who=%0d addr=%h data=%h expected who=%0d addr=%h data=%h",
                               g.who, g.addr, g.data, e.who, e.addr, e.data);
          end
        end
        if (g.who) busy1 = 1'b0; else busy0 = 1'b0;
      end
    end
    checks++;
    if (exp_w.size() != 0 || n >= 200) begin
      errors++; $display("FAIL contest_timeout: got %0d left expected 0", exp_w.size());
    end
  endtask

  task automatic test_concurrent();
    rec_t e, g;
    int n;
    sl_rdata = 32'h1234;
    e = {1'b0, 32'h20, 32'h1234, 2'b00}; exp_r.push_back(e);
    e = {1'b1, 32'h24, 32'h5555AAAA, 2'b00}; exp_w.push_back(e);
    a0_arvalid = 1'b1; a0_araddr = 32'h20;
    issue_write(1'b1, 32'h24, 32'h5555AAAA);
    mstep();
    checks++;
    if ({m_arvalid, m_awvalid, m_araddr, m_awaddr} !== {2'b11, 32'h20, 32'h24}) begin
      errors++; $display("FAIL conc_grant: got v=%b ar=%h aw=%h expected v=11 ar=20 aw=24",
                         {m_arvalid, m_awvalid}, m_araddr, m_awaddr);
    end
    n = 0;
    while ((got_r.size() == 0 || got_w.size() == 0) && n < 10) begin mstep(); n++; end
    checks++;
    if (got_r.size() == 0 || got_w.size() == 0) begin
      errors++; $display("FAIL conc_timeout: got r=%0d w=%0d expected 1 1", got_r.size(), got_w.size());
    end else begin
      if (n != 2) begin
        errors++; $display("FAIL conc_latency: got %0d expected 2", n);
      end
      checks++;
      g = got_r.pop_front(); e = exp_r.pop_front();
      if (g !== e) begin errors++; $display("FAIL conc_read: got %h expected %h", g, e); end
      checks++;
      g = got_w.pop_front(); e = exp_w.pop_front();
      if (g !== e) begin errors++; $display("FAIL conc_write: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_w_before_aw();
    rec_t e, g;
    int n;
    m_awready = 1'b0;
    a0_wvalid = 1'b1; a0_wdata = 32'hCAFEF00D; a0_wstrb = 4'h3;
    #1;
    checks++;
    if (a0_wready !== 1'b0) begin errors++; $display("FAIL wfirst_idle: got %b expected 0", a0_wready); end
    mstep();
    checks++;
    if ({a0_wready, m_wvalid} !== 2'b00) begin
      errors++; $display("FAIL wfirst_hold: got %b expected 00", {a0_wready, m_wvalid});
    end
    w_hs_cnt = 0;
    a0_awvalid = 1'b1; a0_awaddr = 32'h30;
    e = {1'b0, 32'h30, 32'hCAFEF00D, 2'b00}; exp_w.push_back(e);
    mstep();
    repeat (3) mstep();
    checks++;
    if ({got_w.size() == 0, a0_bvalid, m_awvalid, m_wvalid, w_hs_cnt == 1} !== 5'b10101) begin
      errors++; $display("FAIL wfirst_aw_wait: got %b expected 10101",
                         {got_w.size() == 0, a0_bvalid, m_awvalid, m_wvalid, w_hs_cnt == 1});
    end
    m_awready = 1'b1;
    n = 0;
    while (got_w.size() == 0 && n < 10) begin mstep(); n++; end
    checks++;
    if (got_w.size() == 0) begin
      errors++; $display("FAIL wfirst_timeout: got no response expected one");
    end else begin
      g = got_w.pop_front(); e = exp_w.pop_front();
      if (g !== e) begin errors++; $display("FAIL wfirst_resp: got %h expected %h", g, e); end
    end
    checks++;
    if (w_hs_cnt !== 1) begin errors++; $display("FAIL wfirst_w_count: got %0d expected 1", w_hs_cnt); end
  endtask

  task automatic test_backpressure();
    rec_t e, g;
    int n;
    a1_rready = 1'b0;
    sl_rdata = 32'h0BADF00D;
    e = {1'b1, 32'h40, 32'h0BADF00D, 2'b00}; exp_r.push_back(e);
    a1_arvalid = 1'b1; a1_araddr = 32'h40;
    mstep();
    mstep();
    a0_arvalid = 1'b1; a0_araddr = 32'h44;
    sl_rdata = 32'h4444_0044;
    e = {1'b0, 32'h44, 32'h4444_0044, 2'b00}; exp_r.push_back(e);
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({m_rready, a1_rvalid, a0_arready, m_arvalid} !== 4'b0100) begin
        errors++; $display("FAIL bp_hold: cycle %0d got %b expected 0100", c,
                           {m_rready, a1_rvalid, a0_arready, m_arvalid});
      end
      mstep();
    end
    a1_rready = 1'b1;
    n = 0;
    while (got_r.size() < 2 && n < 20) begin mstep(); n++; end
    checks++;
    if (got_r.size() < 2) begin
      errors++; $display("FAIL bp_timeout: got %0d reads expected 2", got_r.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        g = got_r.pop_front(); e = exp_r.pop_front();
        if (g !== e) begin errors++; $display("FAIL bp_read%0d: got %h expected %h", k, g, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, g;
    int n;
    m_awready = 1'b0; m_wready = 1'b0;
    issue_write(1'b1, 32'h50, 32'h5050_5050);
    mstep();
    checks++;
    if ({m_awvalid, m_wvalid} !== 2'b11) begin
      errors++; $display("FAIL mid_in_addr: got %b expected 11", {m_awvalid, m_wvalid});
    end
    aresetn = 1'b0;
    mstep();
    checks++;
    if (all_vr !== 15'h0) begin errors++; $display("FAIL mid_reset_out: got %h expected 0000", all_vr); end
    a1_awvalid = 1'b0; a1_wvalid = 1'b0;
    aresetn = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    mstep();
    checks++;
    if (all_vr !== 15'h0) begin errors++; $display("FAIL mid_after_out: got %h expected 0000", all_vr); end
    e = {1'b0, 32'h60, 32'h6060_6060, 2'b00}; exp_w.push_back(e);
    e = {1'b1, 32'h64, 32'h6464_6464, 2'b00}; exp_w.push_back(e);
    issue_write(1'b0, 32'h60, 32'h6060_6060);
    issue_write(1'b1, 32'h64, 32'h6464_6464);
    n = 0;
    while (got_w.size() < 2 && n < 20) begin mstep(); n++; end
    checks++;
    if (got_w.size() < 2) begin
      errors++; $display("FAIL mid_timeout: got %0d writes expected 2", got_w.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        g = got_w.pop_front(); e = exp_w.pop_front();
        if (g !== e) begin errors++; $display("FAIL mid_order%0d: got %h expected %h", k, g, e); end
      end
    end
  endtask

  task automatic test_isolation();
    checks++;
    if (excl_viol !== 0) begin errors++; $display("FAIL isolation: got %0d expected 0", excl_viol); end
  endtask

  initial begin
    aresetn = 1'b0;
    a0_awvalid = 1'b0; a0_awaddr = '0; a0_wvalid = 1'b0; a0_wdata = '0; a0_wstrb = '0;
    a0_bready = 1'b1; a0_arvalid = 1'b0; a0_araddr = '0; a0_rready = 1'b1;
    a1_awvalid = 1'b0; a1_awaddr = '0; a1_wvalid = 1'b0; a1_wdata = '0; a1_wstrb = '0;
    a1_bready = 1'b1; a1_arvalid = 1'b0; a1_araddr = '0; a1_rready = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    sl_aw = 1'b0; sl_w = 1'b0; sl_bresp = 2'b00; sl_rdata = '0;
    cap_awaddr = '0; cap_wdata = '0; cap_araddr = '0;
    test_reset();
    test_single_write();
    test_contested_writes();
    test_concurrent();
    test_w_before_aw();
    test_backpressure();
    test_reset_mid();
    test_isolation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_2.md
# axil_arbiter_2

Two-master to one-slave AXI4-Lite arbiter with independent read and write arbitration. Masters a0 and a1, for example a PCIe BAR bridge and a local management CPU, share a single AXI4-Lite slave port m, such as the virtio register file. Each channel direction carries at most one outstanding transaction. A grant is held from address acceptance until the response handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports (N in {0,1}):
- aclk  in  1  single clock; all logic on the rising edge.
- aresetn  in  1  synchronous, active-low reset.
- aN_awvalid/aN_awaddr, aN_wvalid/aN_wdata/aN_wstrb, aN_bready  in  1/ADDR/1/DATA/STRB/1  master N write request.
- aN_awready, aN_wready, aN_bvalid, aN_bresp  out  1/1/1/2  master N write handshakes and response.
- aN_arvalid/aN_araddr, aN_rready  in  1/ADDR/1  master N read request.
- aN_arready, aN_rvalid, aN_rdata, aN_rresp  out  1/1/DATA/2  master N read handshakes and data.
- m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready  out  1/ADDR/1/DATA/STRB/1  slave write side.
- m_awready, m_wready, m_bvalid, m_bresp  in  1/1/1/2  slave write handshakes and response.
- m_arvalid, m_araddr, m_rready  out  1/ADDR/1  slave read side.
- m_arready, m_rvalid, m_rdata, m_rresp  in  1/1/DATA/2  slave read handshakes and data.

## Operation
- Write FSM states:
  - W_IDLE: a request is any aN_awvalid. Pick the winner, register wgnt, and move to W_ADDR.
  - W_ADDR: forward AW and W of the winner independently.
    - m_awvalid = aG_awvalid & ~aw_done.
    - m_wvalid = aG_wvalid & ~w_done.
    - Set aw_done/w_done on each m handshake.
    - Go to W_RESP when both are done, including in the same cycle.
  - W_RESP: route m_bvalid to aG_bvalid and aG_bready to m_bready. On the handshake, update wlast = G and return to W_IDLE.
- Read FSM, same scheme:
  - R_IDLE: arbitrate on any aN_arvalid, register rgnt, move to R_ADDR.
  - R_ADDR: forward AR; on the m_arready handshake go to R_DATA.
  - R_DATA: route R; on the rvalid&rready handshake update rlast and return to R_IDLE.
- The read and write FSMs are fully independent. Read and write may be granted to different masters concurrently.
- Winner selection: when only one master requests, it wins. When both request, priority follows the configuration below.
- Non-granted master: every ready and valid output toward it is 0.
- aN_rdata/aN_rresp/aN_bresp are driven directly from m_* to both masters; only the valids are gated.
- m_awaddr/m_wdata/m_wstrb/m_araddr are muxed by the registered grant and are combinational from the master inputs.
- Reset:
  - FSMs go to IDLE, done flags clear, wlast = rlast = 1 so a0 is favoured first.
  - All valid and ready outputs are 0 during and after reset until the next grant.
  - Reset mid-transaction abandons the transaction silently; no response is generated.

## Timing
- Arbitration costs one cycle. The earliest m_awvalid/m_arvalid is the cycle after aN_*valid is first seen in IDLE.
- Address, data and response paths are combinational pass-through while granted, so the m-side handshake is the master-side handshake in the same cycle.
- Back-to-back: the response handshake cycle returns the FSM to IDLE, and the next grant follows one cycle later. Minimum write occupancy is 3 cycles; minimum read occupancy is 3 cycles.
- aN_wvalid asserted before aN_awvalid is held off: wready = 0 until the grant.
- The request is sampled only in IDLE. A master deasserting valid before its grant is an AXI protocol violation and is not supported.

## Configuration
- AXIL_ARB_RR_EN defined:
  - Round-robin per channel.
  - On a simultaneous request the winner is the master not equal to wlast (writes) or rlast (reads).
- AXIL_ARB_RR_EN undefined:
  - Fixed priority: a0 always wins a simultaneous request.
  - wlast/rlast are not implemented.

## Test plan
- Single write by a1:
  - Stimulus: awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF; slave bresp=0.
  - Required: m_awaddr=0x10 and m_wdata=0xDEADBEEF one cycle after request; a1_bvalid=1 with bresp=0; a0 sees no ready or valid.
- Simultaneous writes by a0 and a1, repeated 4 times:
  - With RR: grants alternate a0, a1, a0, a1.
  - Without RR: a0 wins every contested round.
- Concurrent traffic:
  - Stimulus: a0 read of 0x20 while a1 writes 0x24; slave returns rdata=0x1234.
  - Required: both complete without blocking each other; a0_rdata=0x1234.
- W-before-AW on a0, slave m_awready delayed 3 cycles:
  - W accepted first and held (w_done set).
  - State becomes W_RESP only after the AW handshake.
  - Exactly one m_wvalid handshake occurs.
- Response backpressure:
  - Stimulus: a1_rready=0 for 5 cycles with m_rvalid=1.
  - Required: m_rready=0 throughout; the grant is held; a0 read requests wait in R_IDLE.
- Reset mid-transaction:
  - Stimulus: aresetn=0 while in W_ADDR.
  - Required: next cycle all valid/ready outputs are 0 and the FSM is in W_IDLE; the next contested request goes to a0.
